// File: rtl/train_led_pkg.sv
// train_led_pkg: shared defaults and receiver state for the LED chain node
package train_led_pkg;
  localparam int NCH_DEF = 3;
  localparam int PWM_W_DEF = 4;
  localparam int BIT_T_DEF = 12;
  localparam int SAMPLE_T_DEF = 6;
  localparam int IDLE_T_DEF = 96;
  typedef enum logic {RECV, FWD} state_t;
endpackage

// File: rtl/train_led_pwm_ch.sv
// train_led_pwm_ch: one PWM channel, duty register plus registered comparator
module train_led_pwm_ch import train_led_pkg::*; #(
  parameter int PWM_W = PWM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [PWM_W-1:0] duty_i,
  input  logic [PWM_W-1:0] cnt_i,
  output logic             led_o
);
  logic [PWM_W-1:0] duty_q;
  logic led_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      duty_q <= '0;
      led_q <= 1'b0;
    end else begin
      if (load_i) duty_q <= duty_i;
      led_q <= duty_q == '1 || cnt_i < duty_q;
    end
  assign led_o = led_q;
endmodule

// File: rtl/train_led_chain.sv
// train_led_chain: self-timed serial LED chain node, keeps the first frame and forwards the rest
module train_led_chain import train_led_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int PWM_W = PWM_W_DEF,
  parameter int BIT_T = BIT_T_DEF,
  parameter int SAMPLE_T = SAMPLE_T_DEF,
  parameter int IDLE_T = IDLE_T_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           din,
  output logic           dout,
  output logic [NCH-1:0] led,
  output logic           frame_done,
  output logic           frame_err
);
  localparam int NBITS = NCH * PWM_W;
  localparam int FW = $clog2(BIT_T);
  localparam int IW = $clog2(IDLE_T + 1);
  localparam int BW = $clog2(NBITS + 1);
  logic [1:0] sync_q;
  logic din_s, sample, frame_end, fe_ok, fe_bad, load;
  logic [FW-1:0] fc_q, fc_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [BW-1:0] bc_q, bc_d;
  logic [NBITS-1:0] shift_q, shift_d, shadow_q, shadow_d;
  logic [PWM_W-1:0] cnt_q;
  logic pend_q, pend_d, dout_q, dout_d, done_q, err_q;
  state_t state_q, state_d;
  assign din_s = sync_q[1];
  always_comb begin
    fc_d = fc_q == '0 ? FW'(din_s) : fc_q != FW'(BIT_T - 1) ? fc_q + 1'b1 : din_s ? fc_q : '0;
    idle_d = fc_q != '0 ? '0 : idle_q == IW'(IDLE_T) ? idle_q : idle_q + 1'b1;
    sample = fc_q == FW'(SAMPLE_T);
    frame_end = fc_q == '0 && idle_q == IW'(IDLE_T - 1);
    fe_ok = frame_end && bc_q == BW'(NBITS);
    fe_bad = frame_end && bc_q != '0 && bc_q != BW'(NBITS);
    load = cnt_q == '1 && pend_q;
    pend_d = fe_ok | (pend_q & ~load);
    shadow_d = fe_ok ? shift_q : shadow_q;
    state_d = state_q;
    shift_d = shift_q;
    bc_d = bc_q;
    dout_d = 1'b0;
    if (frame_end) begin
      state_d = RECV;
      shift_d = '0;
      bc_d = '0;
    end else if (state_q == RECV) begin
      if (sample) begin
        shift_d = {shift_q[NBITS-2:0], din_s};
        bc_d = bc_q + 1'b1;
        if (bc_q == BW'(NBITS - 1)) state_d = FWD;
      end
    end else begin
      // regenerated cell: rise at 1, data at SAMPLE_T, forced low at BIT_T-2
      dout_d = fc_q == FW'(1) ? 1'b1 : sample ? din_s : fc_q == FW'(BIT_T - 2) ? 1'b0 : dout_q;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      fc_q <= '0;
      idle_q <= '0;
      bc_q <= '0;
      shift_q <= '0;
      shadow_q <= '0;
      cnt_q <= '0;
      pend_q <= 1'b0;
      dout_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      state_q <= RECV;
    end else begin
      sync_q <= {sync_q[0], din};
      fc_q <= fc_d;
      idle_q <= idle_d;
      bc_q <= bc_d;
      shift_q <= shift_d;
      shadow_q <= shadow_d;
      cnt_q <= cnt_q + 1'b1;
      pend_q <= pend_d;
      dout_q <= dout_d;
      done_q <= fe_ok;
      err_q <= fe_bad;
      state_q <= state_d;
    end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    train_led_pwm_ch #(.PWM_W(PWM_W)) u_ch (
      .clk(clk),
      .rst(rst),
      .load_i(load),
      .duty_i(shadow_q[i*PWM_W +: PWM_W]),
      .cnt_i(cnt_q),
      .led_o(led[i])
    );
  end
  assign dout = dout_q;
  assign frame_done = done_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_train_led_chain.sv
// tb_train_led_chain: bit-queue reference model with per-cycle compare plus directed frame scenarios
module tb_train_led_chain;
  localparam int NCH = 3, PWM_W = 4, BIT_T = 12, SAMPLE_T = 6, IDLE_T = 96;
  localparam int NBITS = NCH * PWM_W, PER = 1 << PWM_W;
  logic clk = 1'b0, rst = 1'b1, din = 1'b0;
  logic dout, frame_done, frame_err;
  logic [NCH-1:0] led;
  int passed = 0, total = 0;
  train_led_chain dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout), .led(led),
    .frame_done(frame_done), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  // reference: cells tracked by start cycle, received bits kept in a queue, PWM by cycle index
  int k, start, last_busy, pos, bitv, h1, h2, cur;
  bit in_cell, pend, fwd_cell;
  int duty[NCH], shadow[NCH];
  int rx[$];
  logic e_dout = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [NCH-1:0] e_led = '0;
  always @(posedge clk) begin
    if (rst) begin
      h1 = 0; h2 = 0; in_cell = 0; pend = 0; k = 0; last_busy = -1; rx.delete();
      for (int c = 0; c < NCH; c++) begin duty[c] = 0; shadow[c] = 0; end
      e_dout = 0; e_led = '0; e_done = 0; e_err = 0;
    end else begin
      cur = h2; h2 = h1; h1 = int'(din);
      for (int c = 0; c < NCH; c++) e_led[c] = duty[c] == PER - 1 || (k % PER) < duty[c];
      if (k % PER == PER - 1 && pend) begin duty = shadow; pend = 0; end
      e_done = 0; e_err = 0; e_dout = 0;
      if (in_cell) begin
        last_busy = k;
        pos = k - start;
        if (pos == SAMPLE_T) begin bitv = cur; rx.push_back(cur); end
        e_dout = fwd_cell && ((pos >= 1 && pos < SAMPLE_T) || (pos >= SAMPLE_T && pos <= BIT_T - 3 && bitv == 1));
        if (pos == BIT_T - 1) begin
          if (cur == 1) start++;
          else in_cell = 0;
        end
      end else begin
        if (k - last_busy == IDLE_T) begin
          if (rx.size() >= NBITS) begin
            for (int c = 0; c < NCH; c++) begin
              shadow[c] = 0;
              for (int b = 0; b < PWM_W; b++) shadow[c] = shadow[c] * 2 + rx[(NCH - 1 - c) * PWM_W + b];
            end
            pend = 1; e_done = 1;
          end else if (rx.size() > 0) e_err = 1;
          rx.delete();
        end
        if (cur == 1) begin in_cell = 1; start = k; fwd_cell = rx.size() >= NBITS; end
      end
      k++;
    end
  end
  always @(negedge clk) begin
    chk("dout", int'(dout), rst ? 0 : int'(e_dout));
    chk("led", int'(led), rst ? 0 : int'(e_led));
    chk("frame_done", int'(frame_done), rst ? 0 : int'(e_done));
    chk("frame_err", int'(frame_err), rst ? 0 : int'(e_err));
  end
  int run = 0, done_cnt = 0, err_cnt = 0;
  int widths[$];
  always @(negedge clk) begin
    if (dout === 1'b1) run++;
    else if (run > 0) begin widths.push_back(run); run = 0; end
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end
  task automatic send_bit(input int b);
    din = 1'b1;
    repeat (b ? 9 : 3) @(negedge clk);
    din = 1'b0;
    repeat (b ? BIT_T - 9 : BIT_T - 3) @(negedge clk);
  endtask
  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(int'(v[i]));
  endtask
  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic leds(input string tag, input int x2, input int x1, input int x0);
    int c[NCH];
    for (int i = 0; i < NCH; i++) c[i] = 0;
    repeat (PER) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) c[i] += int'(led[i]);
    end
    chk({tag, "_led2_high"}, c[2], x2);
    chk({tag, "_led1_high"}, c[1], x1);
    chk({tag, "_led0_high"}, c[0], x0);
  endtask
  initial begin
    int fw[8];
    fw = '{9, 5, 9, 9, 5, 5, 9, 5};
    repeat (3) @(negedge clk);
    chk("rst_dout", int'(dout), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_done", int'(frame_done), 0);
    rst = 1'b0;
    idle(100);
    chk("quiet_done", done_cnt, 0);
    chk("quiet_err", err_cnt, 0);
    send(12'b1111_0000_1010, 12); idle(130);
    chk("f1_done", done_cnt, 1);
    chk("f1_err", err_cnt, 0);
    leds("f1", 16, 0, 10);
    widths.delete();
    send(20'b0101_0011_0110_1011_0010, 20); idle(130);
    chk("fwd_pulses", widths.size(), 8);
    for (int i = 0; i < 8; i++) chk("fwd_width", widths.size() > i ? widths[i] : -1, fw[i]);
    chk("f2_done", done_cnt, 2);
    leds("f2", 5, 3, 6);
    send(7'b1010101, 7); idle(130);
    chk("short_err", err_cnt, 1);
    chk("short_done", done_cnt, 2);
    leds("short", 5, 3, 6);
    send(12'b1111_0000_0011, 12); idle(130);
    send(12'b1111_0000_1001, 12); idle(130);
    chk("two_done", done_cnt, 4);
    leds("two", 16, 0, 9);
    send(12'b0000_1111_0001, 12); idle(95);
    send(12'b1111_0000_0110, 12); idle(130);
    chk("coinc_done", done_cnt, 6);
    chk("coinc_err", err_cnt, 1);
    leds("coinc", 16, 0, 6);
    send(5'b10110, 5);
    din = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    chk("pre_rst_led2", int'(led[2]), 1);
    rst = 1'b1; #1;
    chk("arst_dout", int'(dout), 0);
    chk("arst_led", int'(led), 0);
    chk("arst_done", int'(frame_done), 0);
    chk("arst_err", int'(frame_err), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; din = 1'b0;
    idle(20);
    send(12'b1000_0100_0010, 12); idle(130);
    chk("post_rst_done", done_cnt, 7);
    chk("post_rst_err", err_cnt, 1);
    leds("post_rst", 8, 4, 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
